// File: rtl/axi_chan_pkg.sv
// Shared widths and defaults for the AXI channel elastic buffer.
package axi_chan_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// No reset on storage; validity is tracked by the owner's occupancy count.
module axi_fifo_mem
  import axi_chan_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_chan_fifo.sv
// DEPTH-entry first-word-fall-through VALID/READY buffer; a push at edge N is visible after edge N.
// s_READY is registered (drops when full or after flush); m_* depend only on state, never on s_*.
module axi_chan_fifo
  import axi_chan_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      flush,
  input  logic                      s_VALID,
  output logic                      s_READY,
  input  logic [WIDTH-1:0]          s_DATA,
  output logic                      m_VALID,
  input  logic                      m_READY,
  output logic [WIDTH-1:0]          m_DATA,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic             push, pop;
  logic             not_empty;
  logic [WIDTH-1:0] rdata;

  assign not_empty = (count_q != '0);

  always_comb begin
    // Flush wins over any handshake in the same cycle.
    push      = s_VALID && s_ready_q && !flush;
    pop       = not_empty && m_READY && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    s_ready_d = !flush && (count_d < DEPTH_C);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

  axi_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (ACLK),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (s_DATA),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Storage is not reset, so the head is masked to zero whenever nothing is held.
  assign m_DATA      = not_empty ? rdata : '0;
  assign m_VALID     = not_empty;
  assign s_READY     = s_ready_q;
  assign count       = count_q;
  assign empty       = !not_empty;
  assign almost_full = (count_q >= AFULL_C);

endmodule
